player_score_bank: RTL

- Downstream consumer of the access controller's game outputs: `playerAddress`, `score` and `gameEnd`.
- On each completed game it records the active player's final score into a per-player slot.
- Tracks the best score, the winning player and ties, and flags when every authenticated player has played.
- Drives the score display/winner logic at top level.

---
 rtl/player_score_bank_if.sv | 30 +++
 rtl/player_score_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/player_score_bank_if.sv
// rtl/player_score_bank_if.sv - game-record and score-display bus for player_score_bank
// master drives records and display select; slave is the score bank.
interface player_score_bank_if #(
  parameter int SCORE_W = 5,
  parameter int ADDR_W  = 3
);
  logic [ADDR_W-1:0]  playerAddress;
  logic [3:0]         playerNum;
  logic [SCORE_W-1:0] score;
  logic               gameEnd;
  logic               clear;
  logic [ADDR_W-1:0]  viewAddress;
  logic [SCORE_W-1:0] viewScore;
  logic [SCORE_W-1:0] bestScore;
  logic [ADDR_W-1:0]  bestPlayer;
  logic               tie;
  logic               recordValid;
  logic               errFlag;
  logic               allDone;

  modport master (
    output playerAddress, playerNum, score, gameEnd, clear, viewAddress,
    input  viewScore, bestScore, bestPlayer, tie, recordValid, errFlag, allDone
  );

  modport slave (
    input  playerAddress, playerNum, score, gameEnd, clear, viewAddress,
    output viewScore, bestScore, bestPlayer, tie, recordValid, errFlag, allDone
  );
endinterface

// File: rtl/player_score_bank.sv
// rtl/player_score_bank.sv - per-player final score store with best/winner/tie tracking
// Optional SCORE_ACCUM_EN: repeat records for a played slot accumulate (saturating) instead of erroring.
module player_score_bank #(
  parameter int NUM_PLAYERS = 8,
  parameter int SCORE_W     = 5,
  parameter int ADDR_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  player_score_bank_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, COMPARE, DONE} state_t;

  state_t state, next_state;

  logic [SCORE_W-1:0]     slots [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] played;
  logic [ADDR_W-1:0]      stg_addr;
  logic [SCORE_W-1:0]     stg_score;
  logic [SCORE_W-1:0]     best_score;
  logic [ADDR_W-1:0]      best_player;
  logic                   best_valid;
  logic                   tie_q;
  logic                   record_valid;
  logic                   err_flag;
  logic                   all_done;
  logic                   game_end_d;

  logic                   game_edge;
  int                     eff_num;
  logic                   out_of_range;
  logic                   reject;
  logic                   all_covered;
  logic [SCORE_W-1:0]     wr_val;

  assign game_edge = bus.gameEnd & ~game_end_d;

  always_comb begin
    eff_num = int'(bus.playerNum);
    if (bus.playerNum == 4'd0)
      eff_num = 1;
    else if (int'(bus.playerNum) > NUM_PLAYERS)
      eff_num = NUM_PLAYERS;
  end

  assign out_of_range = (int'(stg_addr) >= eff_num);

`ifdef SCORE_ACCUM_EN
  logic [SCORE_W:0] acc_sum;
  assign acc_sum = {1'b0, slots[stg_addr]} + {1'b0, stg_score};
  assign reject  = out_of_range;
  always_comb begin
    wr_val = stg_score;
    if (played[stg_addr])
      wr_val = acc_sum[SCORE_W] ? {SCORE_W{1'b1}} : acc_sum[SCORE_W-1:0];
  end
`else
  assign reject = out_of_range || played[stg_addr];
  assign wr_val = stg_score;
`endif

  // Played bits are registered in WRITE, so COMPARE already sees the current record.
  always_comb begin
    all_covered = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (i < eff_num && !played[i])
        all_covered = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (game_edge) next_state = CHECK;
      CHECK:   next_state = reject ? IDLE : WRITE;
      WRITE:   next_state = COMPARE;
      COMPARE: next_state = all_covered ? DONE : IDLE;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
    if (bus.clear)
      next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++)
        slots[i] <= '0;
      played       <= '0;
      stg_addr     <= '0;
      stg_score    <= '0;
      best_score   <= '0;
      best_player  <= '0;
      best_valid   <= 1'b0;
      tie_q        <= 1'b0;
      record_valid <= 1'b0;
      err_flag     <= 1'b0;
      all_done     <= 1'b0;
      game_end_d   <= 1'b0;
    end else begin
      // Edge history keeps sampling through clear so a held level cannot retrigger.
      game_end_d   <= bus.gameEnd;
      record_valid <= 1'b0;
      err_flag     <= 1'b0;
      if (bus.clear) begin
        for (int i = 0; i < NUM_PLAYERS; i++)
          slots[i] <= '0;
        played      <= '0;
        stg_addr    <= '0;
        stg_score   <= '0;
        best_score  <= '0;
        best_player <= '0;
        best_valid  <= 1'b0;
        tie_q       <= 1'b0;
        all_done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (game_edge) begin
              stg_addr  <= bus.playerAddress;
              stg_score <= bus.score;
            end
          end
          CHECK: begin
            if (reject)
              err_flag <= 1'b1;
          end
          WRITE: begin
            slots[stg_addr]  <= wr_val;
            played[stg_addr] <= 1'b1;
            stg_score        <= wr_val;
          end
          COMPARE: begin
            if (!best_valid || stg_score > best_score) begin
              best_score  <= stg_score;
              best_player <= stg_addr;
              tie_q       <= 1'b0;
              best_valid  <= 1'b1;
            end else if (stg_score == best_score) begin
              tie_q <= 1'b1;
              if (stg_addr < best_player)
                best_player <= stg_addr;
            end
            record_valid <= 1'b1;
            if (all_covered)
              all_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.viewScore = '0;
    if (int'(bus.viewAddress) < NUM_PLAYERS && played[bus.viewAddress])
      bus.viewScore = slots[bus.viewAddress];
  end

  assign bus.bestScore   = best_score;
  assign bus.bestPlayer  = best_player;
  assign bus.tie         = tie_q;
  assign bus.recordValid = record_valid;
  assign bus.errFlag     = err_flag;
  assign bus.allDone     = all_done;

endmodule
